// File: rtl/register_file.sv
// register_file: 2-read / 1-write register file with a power-up clear sequence.
// After Reset deasserts, a clear state machine zeroes one register per clock.
// Busy is high while clearing. During that time writes are ignored and both
// read ports return 0. Register 0 is hard-wired to zero.
//
// Parameters:
//   DATA_WIDTH  register and data-port width (default 16)
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH (default 4 -> 16 regs)
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   WriteEnable  in   write request
//   WriteAddr    in   write index (from the RegDest mux)
//   WriteData    in   write-back value
//   ReadAddrA/B  in   read indices
//   ReadDataA/B  out  combinational read data
//   Busy         out  high while the clear sequence runs
// Optional feature:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written
//                      in the same cycle returns WriteData combinationally.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadAddrA,
  input  logic [ADDR_WIDTH-1:0] ReadAddrB,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  output logic                  Busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic                    write_ok;
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;

  assign write_ok = WriteEnable && (state_q == RUN) && (WriteAddr != '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d     = mem_q;
    case (state_q)
      CLEAR: begin
        mem_d[clr_cnt_q] = '0;
        // The counter holds at its terminal value on leaving CLEAR.
        // A second clear pass only starts after another Reset.
        if (clr_cnt_q == '1) state_d = RUN;
        else                 clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      end
      default: begin
        if (write_ok) mem_d[WriteAddr] = WriteData;
      end
    endcase
    mem_d[0] = '0;
  end

  // Storage is not reset directly. The clear sequence zeroes it. A write
  // pending in a Reset cycle is dropped because mem_q holds its value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (state_q == RUN) begin
      if (ReadAddrA != '0) rd_a = mem_q[ReadAddrA];
      if (ReadAddrB != '0) rd_b = mem_q[ReadAddrB];
`ifdef REGFILE_BYPASS_EN
      if (write_ok && (ReadAddrA == WriteAddr)) rd_a = WriteData;
      if (write_ok && (ReadAddrB == WriteAddr)) rd_b = WriteData;
`else
      // Same-cycle reads of the written register see the old value.
`endif
    end
  end

  assign ReadDataA = rd_a;
  assign ReadDataB = rd_b;
  assign Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        Clock;
  logic        Reset;
  logic        WriteEnable;
  logic [3:0]  WriteAddr;
  logic [15:0] WriteData;
  logic [3:0]  ReadAddrA;
  logic [3:0]  ReadAddrB;
  logic [15:0] ReadDataA;
  logic [15:0] ReadDataB;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int n;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WriteEnable(WriteEnable),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddrA  (ReadAddrA),
    .ReadAddrB  (ReadAddrB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .Busy       (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge, just after the last Reset edge, with Reset
  // already low. Counts the Busy cycles, starting with the current one.
  task automatic wait_clear(output int cnt);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Busy) cnt++;
      else break;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    WriteEnable = 1'b1;
    WriteAddr   = a;
    WriteData   = d;
    @(negedge Clock);
    WriteEnable = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0;
    ReadAddrA = 4'd3; ReadAddrB = 4'd0;

    // Hold reset for 3 edges, then release it.
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_rda", 32'(ReadDataA), 32'h0);
    chk("rst_rdb", 32'(ReadDataB), 32'h0);
    Reset = 1'b0;
    // A write attempt during clear must be ignored.
    WriteEnable = 1'b1; WriteAddr = 4'd3; WriteData = 16'hAAAA;
    #1;
    chk("busy_rda_zero", 32'(ReadDataA), 32'h0);
    wait_clear(n);
    WriteEnable = 1'b0;
    chk("clear_len", 32'(n), 32'd16);
    chk("busy_low", 32'(Busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      ReadAddrA = 4'(i);
      ReadAddrB = 4'(15 - i);
      #1;
      chk("cleared_a", 32'(ReadDataA), 32'h0);
      chk("cleared_b", 32'(ReadDataB), 32'h0);
      @(negedge Clock);
    end
    ReadAddrA = 4'd3; #1;
    chk("r3_ignored", 32'(ReadDataA), 32'h0);

    wr(4'd5, 16'h1234);
    ReadAddrA = 4'd5; #1;
    chk("r5", 32'(ReadDataA), 32'h1234);

    ReadAddrA = 4'd0;
    WriteEnable = 1'b1; WriteAddr = 4'd0; WriteData = 16'hFFFF; #1;
    chk("r0_same_cycle", 32'(ReadDataA), 32'h0);
    @(negedge Clock);
    WriteEnable = 1'b0; #1;
    chk("r0_after", 32'(ReadDataA), 32'h0);

    wr(4'd2, 16'h0011);
    wr(4'd9, 16'h0900);
    ReadAddrA = 4'd2; ReadAddrB = 4'd9; #1;
    chk("dual_a", 32'(ReadDataA), 32'h0011);
    chk("dual_b", 32'(ReadDataB), 32'h0900);
    ReadAddrA = 4'd9; #1;
    chk("same_a", 32'(ReadDataA), 32'h0900);
    chk("same_b", 32'(ReadDataB), 32'h0900);

    // Same-cycle write and read of R7.
    ReadAddrA = 4'd7; ReadAddrB = 4'd7;
    WriteEnable = 1'b1; WriteAddr = 4'd7; WriteData = 16'h00BE; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_a", 32'(ReadDataA), 32'h00BE);
    chk("bypass_b", 32'(ReadDataB), 32'h00BE);
`else
    chk("nobypass_a", 32'(ReadDataA), 32'h0);
    chk("nobypass_b", 32'(ReadDataB), 32'h0);
`endif
    @(negedge Clock);
    WriteEnable = 1'b0; #1;
    chk("r7_after", 32'(ReadDataA), 32'h00BE);

    // Reset in RUN with a pending write to R6. The write must be dropped.
    Reset = 1'b1; WriteEnable = 1'b1; WriteAddr = 4'd6; WriteData = 16'h5555;
    @(negedge Clock);
    Reset = 1'b0; WriteEnable = 1'b0;
    chk("rerst_busy", 32'(Busy), 32'd1);
    chk("rerst_rda", 32'(ReadDataA), 32'h0);
    wait_clear(n);
    chk("rerst_len", 32'(n), 32'd16);
    ReadAddrA = 4'd6; ReadAddrB = 4'd5; #1;
    chk("r6_dropped", 32'(ReadDataA), 32'h0);
    chk("r5_recleared", 32'(ReadDataB), 32'h0);

    // Pulse Reset partway through the clear sequence. Clearing restarts.
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (8) @(negedge Clock);
    chk("mid_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    wait_clear(n);
    chk("mid_len", 32'(n), 32'd16);

    // The counter saturates: RUN must persist with no second clear pass.
    wr(4'd4, 16'hC0DE);
    repeat (20) @(negedge Clock);
    ReadAddrA = 4'd4; #1;
    chk("run_hold_busy", 32'(Busy), 32'd0);
    chk("run_hold_r4", 32'(ReadDataA), 32'hC0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; depth = 2**ADDR_WIDTH (16).
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 WriteEnable  input  1  SHALL request a write of WriteData into WriteAddr at the next rising edge.
REQ-006 WriteAddr  input  ADDR_WIDTH  SHALL be the destination register index, driven by the upstream RegDest mux output.
REQ-007 WriteData  input  DATA_WIDTH  SHALL be the write-back value.
REQ-008 ReadAddrA  input  ADDR_WIDTH  SHALL be the read port A index.
REQ-009 ReadAddrB  input  ADDR_WIDTH  SHALL be the read port B index.
REQ-010 ReadDataA  output  DATA_WIDTH  SHALL be the port A read data.
REQ-011 ReadDataB  output  DATA_WIDTH  SHALL be the port B read data.
REQ-012 Busy  output  1  SHALL be high while the clear sequence runs; no writes are accepted.

Function
REQ-013 Reads SHALL be combinational: ReadDataX = reg[ReadAddrX] in the same cycle, with zero clock latency.
REQ-014 Register 0 SHALL always read 0; writes to address 0 SHALL be dropped.
REQ-015 A write with WriteEnable=1, Busy=0 and WriteAddr!=0 SHALL update reg[WriteAddr] at the rising edge, so it is visible on reads in the following cycle.
REQ-016 The state machine SHALL have two states: CLEAR (Busy=1) and RUN (Busy=0).
REQ-017 In CLEAR, a 4-bit clear counter SHALL zero reg[counter] on each edge and increment by 1.
REQ-018 The transition CLEAR->RUN SHALL occur on the edge at which counter==15 is cleared, so CLEAR lasts exactly 16 cycles after Reset deasserts.
REQ-019 The clear counter SHALL saturate with no wrap into a second pass; RUN SHALL be held until the next Reset.
REQ-020 While Busy=1, WriteEnable SHALL be ignored and both ReadData outputs SHALL be 0.
REQ-021 When both read ports address the same register, both ports SHALL return the identical value.
REQ-022 Behaviour on a write that coincides with a read of the same address SHALL be governed by REQ-028/REQ-029.

Reset
REQ-023 While Reset=1 at an edge: state SHALL be CLEAR, counter SHALL be 0, and Busy SHALL be 1 on the next cycle.
REQ-024 Held Reset SHALL keep the counter at 0; clearing SHALL begin on the first edge with Reset=0.
REQ-025 Reset asserted mid-CLEAR SHALL restart the sequence from counter 0.
REQ-026 Reset asserted in RUN SHALL re-enter CLEAR; a write pending in the same cycle SHALL be dropped.
REQ-027 Output reset values: Busy=1, ReadDataA=0, ReadDataB=0.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, a read whose address equals WriteAddr SHALL return WriteData combinationally in the same cycle, provided WriteEnable=1, Busy=0 and WriteAddr!=0.
REQ-029 Without REGFILE_BYPASS_EN, such a read SHALL return the old stored value until the edge.

Verification
REQ-030 Reset high 3 cycles, then low -> Busy=1 for exactly 16 cycles, then 0; all 16 registers read 0.
REQ-031 After clear: write 0x1234 to R5, read A=5 next cycle -> 0x1234; write 0xFFFF to R0 -> R0 reads 0.
REQ-032 Busy=1 with WriteEnable=1, WriteAddr=3, WriteData=0xAAAA -> R3 reads 0 after Busy falls.
REQ-033 Reset pulsed at clear cycle 8 -> Busy remains high 16 further cycles after deassert.
REQ-034 Same-cycle write 0x00BE to R7 with read A=7 -> 0x00BE in that cycle with REGFILE_BYPASS_EN defined; old value (0) without it.
REQ-035 R2=0x0011, R9=0x0900; read A=2, B=9 -> 0x0011 / 0x0900; read A=B=9 -> both 0x0900.
